// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style main controller: state register plus state-decoded datapath controls.
// Controls are decoded from the current state, and the write enables are gated directly by the reset pin.
module multicycle_controller #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic       zeroimm_sel,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic       halted,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6, RTYPEWB = 4'd7,
    BEQEX   = 4'd8,  ADDIEX  = 4'd9,  IMMWB  = 4'd10, JEX   = 4'd11,
    ORIEX   = 4'd12, BNEEX   = 4'd14, HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_RT = 6'b000000,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                         OP_ORI = 6'b001101, OP_J = 6'b000010;

  state_t st;
  logic   pcwrite;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= FETCH;
    else begin
      case (st)
        FETCH:  st <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: st <= MEMADR;
            OP_RT:        st <= RTYPEEX;
            OP_BEQ:       st <= BEQEX;
            OP_BNE:       st <= BNEEX;
            OP_ADDI:      st <= ADDIEX;
            OP_ORI:       st <= ORIEX;
            OP_J:         st <= JEX;
            default:      st <= HALT_ON_ILLEGAL ? HALT : FETCH;
          endcase
        end
        MEMADR:  st <= (op == OP_LW) ? MEMRD : MEMWR;
        MEMRD:   st <= MEMWB;
        RTYPEEX: st <= RTYPEWB;
        ADDIEX,
        ORIEX:   st <= IMMWB;
        HALT:    st <= HALT;
        // writeback/branch/jump states and unused codes all resume at FETCH
        default: st <= FETCH;
      endcase
    end
  end

  always_comb begin
    iord = 1'b0; irwrite = 1'b0; memwrite = 1'b0; regwrite = 1'b0;
    regdst = 1'b0; memtoreg = 1'b0; alusrca = 1'b0; zeroimm_sel = 1'b0;
    alusrcb = 2'b00; pcsrc = 2'b00; alucontrol = 3'b000; pcwrite = 1'b0;
    case (st)
      FETCH: begin
        irwrite = 1'b1; alusrcb = 2'b01; alucontrol = 3'b010; pcwrite = 1'b1;
      end
      DECODE: begin
        alusrcb = 2'b11; alucontrol = 3'b010;
      end
      MEMADR, ADDIEX: begin
        alusrca = 1'b1; alusrcb = 2'b10; alucontrol = 3'b010;
      end
      ORIEX: begin
        alusrca = 1'b1; alusrcb = 2'b10; zeroimm_sel = 1'b1; alucontrol = 3'b001;
      end
      MEMRD: iord = 1'b1;
      MEMWR: begin
        iord = 1'b1; memwrite = 1'b1;
      end
      MEMWB: begin
        regwrite = 1'b1; memtoreg = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      RTYPEWB: begin
        regwrite = 1'b1; regdst = 1'b1;
      end
      IMMWB: regwrite = 1'b1;
      BEQEX, BNEEX: begin
        alusrca = 1'b1; alucontrol = 3'b110; pcsrc = 2'b01;
      end
      JEX: begin
        pcsrc = 2'b10; pcwrite = 1'b1;
      end
      default: ;
    endcase
    pcen = pcwrite | ((st == BEQEX) & zero) | ((st == BNEEX) & ~zero);
    // state reads FETCH during reset, so its write enables must be masked by the pin itself
    if (!reset) begin
      irwrite = 1'b0; memwrite = 1'b0; regwrite = 1'b0; pcen = 1'b0;
    end
  end

  assign halted = (st == HALT);
  assign state  = st;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: both HALT_ON_ILLEGAL settings run in lockstep.
module tb_multicycle_controller;
  logic       clk = 1'b0, reset = 1'b0, zero = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;

  logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, zeroimm_sel;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       pcen, halted;
  logic [3:0] state;

  logic       iord0, irwrite0, memwrite0, regwrite0, regdst0, memtoreg0, alusrca0, zeroimm_sel0;
  logic [1:0] alusrcb0, pcsrc0;
  logic [2:0] alucontrol0;
  logic       pcen0, halted0;
  logic [3:0] state0;

  int ntests = 0, nfail = 0;

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) u_dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .zeroimm_sel(zeroimm_sel),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .pcen(pcen),
    .halted(halted), .state(state));

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord0), .irwrite(irwrite0), .memwrite(memwrite0), .regwrite(regwrite0),
    .regdst(regdst0), .memtoreg(memtoreg0), .alusrca(alusrca0), .zeroimm_sel(zeroimm_sel0),
    .alusrcb(alusrcb0), .pcsrc(pcsrc0), .alucontrol(alucontrol0), .pcen(pcen0),
    .halted(halted0), .state(state0));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #3;
    chk("rst.state", state, 0);
    chk("rst.pcen", pcen, 0);
    chk("rst.irwrite", irwrite, 0);
    chk("rst.memwrite", memwrite, 0);
    chk("rst.regwrite", regwrite, 0);
    step();
    chk("rst.hold_state", state, 0);
    reset = 1'b1;

    // lw: 0,1,2,3,4,0
    op = 6'b100011; #1;
    chk("fetch.state", state, 0);
    chk("fetch.irwrite", irwrite, 1);
    chk("fetch.pcen", pcen, 1);
    chk("fetch.alusrcb", alusrcb, 2'b01);
    chk("fetch.alucontrol", alucontrol, 3'b010);
    chk("fetch.iord", iord, 0);
    chk("lw.memwrite0", memwrite, 0);
    step(); chk("lw.s1", state, 1); chk("dec.alusrcb", alusrcb, 2'b11);
    chk("dec.pcen", pcen, 0); chk("lw.memwrite1", memwrite, 0); chk("lw.regwrite1", regwrite, 0);
    step(); chk("lw.s2", state, 2); chk("madr.alusrca", alusrca, 1); chk("madr.alusrcb", alusrcb, 2'b10);
    chk("lw.memwrite2", memwrite, 0); chk("lw.regwrite2", regwrite, 0);
    step(); chk("lw.s3", state, 3); chk("mrd.iord", iord, 1);
    chk("lw.memwrite3", memwrite, 0); chk("lw.regwrite3", regwrite, 0); chk("lw.memtoreg3", memtoreg, 0);
    step(); chk("lw.s4", state, 4); chk("mwb.regwrite", regwrite, 1); chk("mwb.memtoreg", memtoreg, 1);
    chk("mwb.regdst", regdst, 0); chk("lw.memwrite4", memwrite, 0);
    step(); chk("lw.s0", state, 0); chk("lw.memtoreg0", memtoreg, 0);

    // beq taken / not taken
    op = 6'b000100;
    step(); chk("beq.s1", state, 1);
    step(); chk("beq.s8", state, 8);
    zero = 1'b1; #1;
    chk("beq.t.pcen", pcen, 1); chk("beq.pcsrc", pcsrc, 2'b01); chk("beq.alu", alucontrol, 3'b110);
    zero = 1'b0; #1;
    chk("beq.nt.pcen", pcen, 0);
    step(); chk("beq.s0", state, 0);

    // bne taken / not taken
    op = 6'b000101;
    step(); step(); chk("bne.s14", state, 14);
    chk("bne.t.pcen", pcen, 1);
    zero = 1'b1; #1;
    chk("bne.nt.pcen", pcen, 0);
    zero = 1'b0;
    step(); chk("bne.s0", state, 0);

    // ori: 0,1,12,10,0
    op = 6'b001101;
    step(); chk("ori.s1", state, 1);
    step(); chk("ori.s12", state, 12); chk("ori.zimm", zeroimm_sel, 1); chk("ori.alu", alucontrol, 3'b001);
    step(); chk("ori.s10", state, 10); chk("immwb.regwrite", regwrite, 1); chk("immwb.regdst", regdst, 0);
    step(); chk("ori.s0", state, 0);

    // addi: 0,1,9,10,0
    op = 6'b001000;
    step(); step(); chk("addi.s9", state, 9); chk("addi.zimm", zeroimm_sel, 0); chk("addi.alu", alucontrol, 3'b010);
    step(); chk("addi.s10", state, 10);
    step(); chk("addi.s0", state, 0);

    // R-type slt, then sub
    op = 6'b000000; funct = 6'b101010;
    step(); step(); chk("rt.s6", state, 6); chk("rt.slt", alucontrol, 3'b111); chk("rt.alusrcb", alusrcb, 2'b00);
    step(); chk("rt.s7", state, 7); chk("rtwb.regdst", regdst, 1); chk("rtwb.regwrite", regwrite, 1);
    chk("rtwb.memtoreg", memtoreg, 0);
    step(); funct = 6'b100010;
    step(); step(); chk("rt.sub", alucontrol, 3'b110);
    funct = 6'b111000; #1; chk("rt.dflt", alucontrol, 3'b010);
    step(); step(); chk("rt2.s0", state, 0);

    // j: 0,1,11,0
    op = 6'b000010;
    step(); step(); chk("j.s11", state, 11); chk("j.pcsrc", pcsrc, 2'b10); chk("j.pcen", pcen, 1);
    step(); chk("j.s0", state, 0);

    // sw, then async reset in MEMWR
    op = 6'b101011;
    step(); step(); chk("sw.s2", state, 2);
    step(); chk("sw.s5", state, 5); chk("mwr.memwrite", memwrite, 1); chk("mwr.iord", iord, 1);
    chk("mwr.irwrite", irwrite, 0);
    #2 reset = 1'b0; #1;
    chk("arst.memwrite", memwrite, 0);
    chk("arst.state", state, 0);
    chk("arst.pcen", pcen, 0);
    chk("arst.irwrite", irwrite, 0);
    step(); chk("arst.hold", state, 0);
    reset = 1'b1;

    // illegal opcode: halt vs. return to fetch
    op = 6'b111111;
    step(); chk("ill.s1", state, 1);
    step();
    chk("ill.s15", state, 15);
    chk("ill0.s0", state0, 0);
    chk("ill0.halted", halted0, 0);
    op = 6'b100011;
    for (int i = 0; i < 12; i++) begin
      chk("halt.state", state, 15);
      chk("halt.halted", halted, 1);
      chk("halt.pcen", pcen, 0);
      chk("halt.irwrite", irwrite, 0);
      step();
    end
    reset = 1'b0; #1;
    chk("halt.rst.state", state, 0);
    chk("halt.rst.halted", halted, 0);
    step(); reset = 1'b1;
    step(); chk("post.s1", state, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter HALT_ON_ILLEGAL, default 1: 1 = undefined opcode enters sticky HALT; 0 = undefined opcode returns to FETCH.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = asserted).
REQ-004 SHALL have port op  input  6  instruction opcode field, instr[31:26], from the instruction register.
REQ-005 SHALL have port funct  input  6  instr[5:0], from the instruction register.
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have outputs iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, zeroimm_sel  output  1 each  datapath controls.
REQ-008 SHALL have outputs alusrcb and pcsrc  output  2 each; alusrcb: 00 = B, 01 = constant 4, 10 = immediate, 11 = immediate<<2; pcsrc: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-009 SHALL have port alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-010 SHALL have port pcen  output  1  PC register write enable.
REQ-011 SHALL have outputs halted  output  1 (high in HALT) and state  output  4 (current state code).

Function
REQ-012 SHALL implement states with these codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, IMMWB 10, JEX 11, ORIEX 12, BNEEX 14, HALT 15.
REQ-013 SHALL make codes 13 and any other unused code transition to FETCH on the next edge.
REQ-014 SHALL transition FETCH->DECODE unconditionally.
REQ-015 SHALL transition DECODE on op as follows: 100011/101011->MEMADR; 000000->RTYPEEX; 000100->BEQEX; 000101->BNEEX; 001000->ADDIEX; 001101->ORIEX; 000010->JEX; other->HALT if HALT_ON_ILLEGAL else FETCH.
REQ-016 SHALL transition MEMADR->MEMRD if op=100011, else ->MEMWR; MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX and ORIEX->IMMWB.
REQ-017 SHALL transition MEMWB, MEMWR, RTYPEWB, IMMWB, BEQEX, BNEEX and JEX ->FETCH.
REQ-018 SHALL hold HALT until reset.
REQ-019 SHALL give these instruction latencies in cycles: lw 5; sw, R-type, addi, ori 4; beq, bne, j 3.
REQ-020 SHALL drive FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, pcwrite=1.
REQ-021 SHALL drive DECODE: alusrca=0, alusrcb=11, alucontrol=010 (branch target precompute).
REQ-022 SHALL drive MEMADR and ADDIEX: alusrca=1, alusrcb=10, zeroimm_sel=0, alucontrol=010.
REQ-023 SHALL drive ORIEX: alusrca=1, alusrcb=10, zeroimm_sel=1, alucontrol=001.
REQ-024 SHALL drive MEMRD: iord=1; MEMWR: iord=1, memwrite=1; MEMWB: regwrite=1, regdst=0, memtoreg=1.
REQ-025 SHALL drive RTYPEEX: alusrca=1, alusrcb=00, alucontrol decoded from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, other 010).
REQ-026 SHALL drive RTYPEWB: regwrite=1, regdst=1, memtoreg=0; IMMWB: regwrite=1, regdst=0, memtoreg=0.
REQ-027 SHALL drive BEQEX and BNEEX: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01.
REQ-028 SHALL drive JEX: pcsrc=10, pcwrite=1.
REQ-029 SHALL hold every control not listed for a state at 0, including in HALT.
REQ-030 SHALL compute pcen = pcwrite | (BEQEX & zero) | (BNEEX & ~zero) combinationally from state and zero; all other outputs SHALL depend on state only (plus funct in RTYPEEX).
REQ-031 SHALL never assert memwrite and irwrite in the same cycle, and SHALL never assert more than one of pcen-causing states simultaneously.

Reset
REQ-032 SHALL, while reset=0, force state=FETCH asynchronously and force pcen, irwrite, regwrite and memwrite to 0 regardless of state.
REQ-033 SHALL, on the first rising edge after reset deasserts, execute FETCH.
REQ-034 SHALL, on reset asserted mid-instruction (e.g. in MEMWR), abort it, drop memwrite to 0 immediately and leave no pending state.
REQ-035 SHALL clear HALT only via reset.

Verification
REQ-036 SHALL be verified with lw (op 100011): state sequence 0,1,2,3,4,0; memwrite never 1; regwrite=1 and memtoreg=1 only in state 4.
REQ-037 SHALL be verified with beq, zero=1 in BEQEX -> pcen=1, pcsrc=01; beq, zero=0 -> pcen=0; bne, zero=0 -> pcen=1.
REQ-038 SHALL be verified with ori (001101): sequence 0,1,12,10,0; zeroimm_sel=1 and alucontrol=001 in state 12.
REQ-039 SHALL be verified with R-type funct=101010: alucontrol=111 in state 6; regdst=1 and regwrite=1 in state 7.
REQ-040 SHALL be verified with op=111111 and HALT_ON_ILLEGAL=1: state 15 after DECODE, halted=1, pcen=0 for 10+ cycles; with HALT_ON_ILLEGAL=0: returns to state 0.
REQ-041 SHALL be verified with reset=0 asserted asynchronously mid-MEMWR: memwrite=0 and state=0 before the next clock edge.
